// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Holds the FSM state encoding, default sizes and the pointer wrap helper.
package reg_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/shared_data_reg.sv
// Shared DATA_W-bit storage register written by the arbiter.
// Clears on reset, loads d when load is high, otherwise holds.
module shared_data_reg #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    // next value: new data on a load, hold otherwise
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    // storage flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared data register.
// Define REG_ARB_PRIO0_EN to give requester 0 fixed top priority.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N_REQ  = DEF_N_REQ,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       q,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id
);

`ifdef REG_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   grant_id_d;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   rr_d;
    logic [DATA_W-1:0] latch_q;
    logic [DATA_W-1:0] latch_d;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [DATA_W-1:0] wd_sel;
    logic              load;
    int                idx;

    // winner search: from rr pointer upward with wrap, first set bit wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        if (PRIO0 && req[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && i == idx && req[i] &&
                    !(PRIO0 && i == 0)) begin
                    found  = 1'b1;
                    winner = ID_W'(i);
                end
            end
        end
    end

    // data slice of the selected requester
    always_comb begin
        wd_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                wd_sel = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM next state, capture and pointer update
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_d       = rr_q;
        latch_d    = latch_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    latch_d    = wd_sel;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                load    = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                // a priority-0 grant leaves the rotation untouched
                if (!(PRIO0 && grant_id_q == '0)) begin
                    rr_d = ID_W'(rr_next(int'(grant_id_q), N_REQ));
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, grant, pointer and data latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_q       <= '0;
            latch_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
            latch_q    <= latch_d;
        end
    end

    // one-hot ack to the granted requester during the ACK cycle
    always_comb begin
        ack = '0;
        if (state_q == ACK) begin
            ack = N_REQ'(1) << grant_id_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;

    shared_data_reg #(
        .DATA_W (DATA_W)
    ) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (latch_q),
        .q     (q)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed cases then random traffic.
// A transaction-level model predicts grants; a monitor checks every ack.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 7;
    localparam int IW = 2;

`ifdef REG_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  ack;
    logic [DW-1:0] q;
    logic          busy;
    logic [IW-1:0] grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int            m_phase = 0;
    int            m_rr    = 0;
    int            m_cur   = 0;
    int            m_last  = 0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_q     = '0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    reg_write_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .q        (q),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        if (PRIO0 && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (PRIO0 && i == 0) continue;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // transaction model: capture, load one cycle later, ack, back to idle
    always @(posedge clk) begin
        int   w;
        exp_t e;
        if (reset) begin
            m_phase = 0;
            m_rr    = 0;
            m_cur   = 0;
            m_last  = 0;
            m_q     = '0;
            sb.delete();
        end else begin
            case (m_phase)
                0: begin
                    w = pick(req, m_rr);
                    if (w >= 0) begin
                        e.id   = w;
                        e.data = wdata[w*DW +: DW];
                        sb.push_back(e);
                        m_cur   = w;
                        m_last  = w;
                        m_data  = e.data;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_q     = m_data;
                    m_phase = 2;
                end
                default: begin
                    if (!(PRIO0 && m_cur == 0)) m_rr = (m_cur + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    end

    // monitor: per-cycle outputs plus scoreboard pop on every ack
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("q", int'(q), int'(m_q));
            chk("grant_id", int'(grant_id), m_last);
            chk("ack_timing", int'(ack != 0), int'(m_phase == 2));
            if (ack != 0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("ack_id", int'(ack), 1 << e.id);
                    chk("ack_q", int'(q), int'(e.data));
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", int'(ok), 1);
    endtask

    task automatic wait_any(input int lim, output int id);
        bit ok = 1'b0;
        id = -1;
        for (int c = 0; c < lim; c++) begin
            @(posedge clk);
            #1;
            if (ack != 0) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (ack[i]) id = i;
                break;
            end
        end
        chk("ack_timeout", int'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int prev;
        int exp_id;
        logic [DW-1:0] rot [N];
        int wrap_exp [2];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gid", int'(grant_id), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single write from requester 2
        wait_idle();
        req = 4'b0100;
        wdata[2*DW +: DW] = 7'h2A;
        @(posedge clk);
        #1;
        chk("sw_busy1", int'(busy), 1);
        chk("sw_gid", int'(grant_id), 2);
        chk("sw_ack0", int'(ack), 0);
        @(posedge clk);
        #1;
        chk("sw_q", int'(q), 'h2A);
        chk("sw_ack", int'(ack), 'b0100);
        chk("sw_busy2", int'(busy), 1);
        req = '0;
        @(posedge clk);
        #1;
        chk("sw_ack_drop", int'(ack), 0);
        chk("sw_idle", int'(busy), 0);

        // pointer now 3: requesters 3 and 0 pending
        wrap_exp[0] = PRIO0 ? 0 : 3;
        wrap_exp[1] = PRIO0 ? 3 : 0;
        req = 4'b1001;
        wdata[3*DW +: DW] = 7'h33;
        wdata[0*DW +: DW] = 7'h66;
        for (int n = 0; n < 2; n++) begin
            wait_any(6, id);
            chk("wrap_id", id, wrap_exp[n]);
            if (id >= 0) req[id] = 1'b0;
        end
        req = '0;

        // requester 1 drops and changes data right after capture
        wait_idle();
        req[1] = 1'b1;
        wdata[1*DW +: DW] = 7'h0F;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        wdata[1*DW +: DW] = 7'h70;
        wait_any(4, id);
        chk("drop_id", id, 1);
        chk("drop_q", int'(q), 'h0F);

        // fresh pointer, all four requesting continuously
        wait_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rot[0] = 7'h11;
        rot[1] = 7'h22;
        rot[2] = 7'h33;
        rot[3] = 7'h44;
        for (int i = 0; i < N; i++) wdata[i*DW +: DW] = rot[i];
        req  = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_any(6, id);
            exp_id = PRIO0 ? 0 : k % N;
            chk("rot_id", id, exp_id);
            chk("rot_q", int'(q), int'(rot[exp_id]));
            if (k > 0) chk("rot_spacing", cyc - prev, 3);
            prev = cyc;
        end
        req = '0;

        // reset in the GRANT cycle aborts the write
        wait_idle();
        req = 4'b0010;
        wdata[1*DW +: DW] = 7'h55;
        @(posedge clk);
        #1;
        chk("rg_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("rg_q", int'(q), 0);
        chk("rg_ack", int'(ack), 0);
        chk("rg_busy0", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_any(5, id);
        chk("rg_id", id, 1);
        chk("rg_q55", int'(q), 'h55);
        req = '0;
        wait_idle();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        req[i] = 1'b1;
                        wdata[i*DW +: DW] = DW'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(2, 0) == 0) wdata[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(399, 0) == 0) begin
                #1;
                reset = 1'b1;
                @(negedge clk);
                #1;
                reset = 1'b0;
            end
        end
        req = '0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one DATA_W-bit storage register between N_REQ requesters.
- Arbitrates write requests round-robin and latches the winner's data.
- Sequences a single-cycle load into the register and returns a one-cycle ack to the winner.
- Sits between multiple producer blocks and the shared data register; the register output fans out to consumers.

Parameters:
N_REQ, 4, number of requesters (>= 2)
DATA_W, 7, width of the shared register and of each requester's write data
ID_W, $clog2(N_REQ), width of grant_id (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester write request, level; held until own ack
wdata  input  N_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W]
ack  output  N_REQ  one-cycle pulse to the requester whose write completed
q  output  DATA_W  shared register contents
busy  output  1  high while a write is in flight (states GRANT, ACK)
grant_id  output  ID_W  index of current/last granted requester

Behaviour:
- Reset (async, active-high): state=IDLE, q=0, ack=0, busy=0, grant_id=0, rr pointer=0, data latch=0. Reset mid-operation aborts the transaction: no load, no ack.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If any req bit is set, select the winner. Search starts at rr pointer and moves upward with wrap; the first set bit wins.
  - Latch grant_id=winner and the latch register = winner's wdata slice, then go to GRANT. The winner's data is captured on that edge.
  - If no req bit is set, stay in IDLE.
- GRANT: internal load asserted this cycle; q takes the latched data on the closing edge. Go to ACK.
- ACK: ack[grant_id]=1 for exactly this cycle; all other ack bits are 0. rr pointer <= grant_id+1, wrapping N_REQ-1 -> 0. Go to IDLE.
- Latency: req sampled high in IDLE at edge E0. q updates at E1 and is visible after E1. ack is high in the cycle after E1 and drops at E2.
- Throughput: at most one write per 3 cycles. IDLE is always visited between transactions.
- busy: high in GRANT and ACK, low in IDLE.
- Requester rules:
  - wdata changes after the capture edge are ignored.
  - If req drops before ack, the write still completes and ack is still pulsed.
  - If req is still high in the IDLE cycle after ack, it counts as a new request; round-robin order puts other pending requesters ahead of it.
- Simultaneous requests: only one is granted per transaction. With all requesters continuously asserting, grants rotate 0,1,2,...,N_REQ-1,0,...
- Single requester continuously asserting: it is granted every transaction regardless of pointer position.
- q changes only on a load edge or on reset; no other path modifies it.

Optional Feature:
- Macro REG_ARB_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req[0]=1 in IDLE it wins regardless of rr pointer. Other requesters are arbitrated round-robin among themselves. Granting requester 0 does not move the rr pointer.
- Undefined: pure round-robin over all N_REQ requesters as above.

Decomposition:
- Package reg_arb_pkg holds:
  - the FSM state enum (IDLE, GRANT, ACK; 2-bit encoding);
  - default DATA_W=7 and N_REQ=4 constants;
  - a function that computes the next rr index with wrap.
- One sub-module: shared_data_reg.
  - Ports: clk, reset, load, d[DATA_W], q[DATA_W].
  - Async active-high reset to 0; loads d when load=1, otherwise holds.
  - Instantiated once; the arbiter drives load/d.

Test Plan:
- Reset mid-GRANT with req[1]=1, wdata[1]=7'h55: reset asserted for one cycle -> q=0, ack=0, busy=0. After release, the request is re-arbitrated and q=7'h55 three cycles later.
- Single write: req[2]=1, wdata[2]=7'h2A in IDLE -> busy=1 for 2 cycles; q=7'h2A after E1; ack=4'b0100 for one cycle; grant_id=2.
- All four req held high with distinct data 7'h11/22/33/44 -> grants in order 0,1,2,3,0. q follows 11,22,33,44,11, with one write every 3 cycles.
- Wrap: pointer at 3, req=4'b1001 -> req 3 granted, then req 0 (pointer wraps to 0).
- Requester 1 drops req and changes wdata right after capture (captured value 7'h0F) -> q=7'h0F and ack[1] still pulses.
- With REG_ARB_PRIO0_EN: req=4'b1111 held -> requester 0 wins every transaction. Without the macro, the same stimulus rotates 0..3.
